// File: rtl/proc_pkg.sv
// proc_pkg: shared datapath widths and register-file types
package proc_pkg;
  localparam int DATA_W = 16;
  localparam int RF_DEPTH = 16;
  typedef logic [DATA_W-1:0] word_t;
  typedef logic [$clog2(RF_DEPTH)-1:0] rf_addr_t;
endpackage

// File: rtl/mux_nw_n_to_1.sv
// mux_nw_n_to_1: combinational N-way word select, zero when select is out of range
module mux_nw_n_to_1 #(
  parameter int WIDTH = 16,
  parameter int N = 16,
  localparam int SW = $clog2(N)
) (
  input  logic [WIDTH-1:0] d [N],
  input  logic [SW-1:0]    sel,
  output logic [WIDTH-1:0] y
);
  always_comb y = 32'(sel) < N ? d[sel] : '0;
endmodule

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: one write port, two registered read ports with optional bypass and zero register
module reg_file_2r1w
  import proc_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = RF_DEPTH,
  parameter int BYPASS = 1,
  parameter int ZERO_REG = 0,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [WIDTH-1:0]  w_data,
  input  logic              ra_en,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic [WIDTH-1:0]  ra_data,
  output logic              ra_valid,
  input  logic              rb_en,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [WIDTH-1:0]  rb_data,
  output logic              rb_valid
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] ma, mb, sa, sb;
  logic w_ok;
  mux_nw_n_to_1 #(.WIDTH(WIDTH), .N(DEPTH)) u_mux_a (.d(mem), .sel(ra_addr), .y(ma));
  mux_nw_n_to_1 #(.WIDTH(WIDTH), .N(DEPTH)) u_mux_b (.d(mem), .sel(rb_addr), .y(mb));
  // w_ok already excludes out-of-range and zero-register writes, so bypass never overrides them
  always_comb begin
    w_ok = w_en && 32'(w_addr) < DEPTH && !(ZERO_REG != 0 && w_addr == '0);
    sa = (ZERO_REG != 0 && ra_addr == '0) ? '0 : (BYPASS != 0 && w_ok && w_addr == ra_addr) ? w_data : ma;
    sb = (ZERO_REG != 0 && rb_addr == '0) ? '0 : (BYPASS != 0 && w_ok && w_addr == rb_addr) ? w_data : mb;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      ra_data <= '0;
      rb_data <= '0;
      ra_valid <= 1'b0;
      rb_valid <= 1'b0;
    end else begin
      if (w_ok) mem[w_addr] <= w_data;
      if (ra_en) ra_data <= sa;
      if (rb_en) rb_data <= sb;
      ra_valid <= ra_en;
      rb_valid <= rb_en;
    end
  end
endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: three configurations driven in lockstep against a behavioural model
module tb_reg_file_2r1w;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic w_en = 1'b0, ra_en = 1'b0, rb_en = 1'b0;
  logic [3:0] w_addr = '0, ra_addr = '0, rb_addr = '0;
  logic [15:0] w_data = '0;
  logic [15:0] ra_d [3], rb_d [3];
  logic ra_v [3], rb_v [3];
  int dep [3] = '{16, 16, 10};
  int byp [3] = '{1, 0, 1};
  int zr [3] = '{0, 1, 1};
  logic [15:0] m [3][16];
  logic [15:0] ea_d [3], eb_d [3];
  logic ea_v [3], eb_v [3];
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  reg_file_2r1w #(.WIDTH(16), .DEPTH(16), .BYPASS(1), .ZERO_REG(0)) u_dut0 (
    .clk(clk), .reset(reset), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .ra_en(ra_en), .ra_addr(ra_addr), .ra_data(ra_d[0]), .ra_valid(ra_v[0]),
    .rb_en(rb_en), .rb_addr(rb_addr), .rb_data(rb_d[0]), .rb_valid(rb_v[0]));
  reg_file_2r1w #(.WIDTH(16), .DEPTH(16), .BYPASS(0), .ZERO_REG(1)) u_dut1 (
    .clk(clk), .reset(reset), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .ra_en(ra_en), .ra_addr(ra_addr), .ra_data(ra_d[1]), .ra_valid(ra_v[1]),
    .rb_en(rb_en), .rb_addr(rb_addr), .rb_data(rb_d[1]), .rb_valid(rb_v[1]));
  reg_file_2r1w #(.WIDTH(16), .DEPTH(10), .BYPASS(1), .ZERO_REG(1)) u_dut2 (
    .clk(clk), .reset(reset), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .ra_en(ra_en), .ra_addr(ra_addr), .ra_data(ra_d[2]), .ra_valid(ra_v[2]),
    .rb_en(rb_en), .rb_addr(rb_addr), .rb_data(rb_d[2]), .rb_valid(rb_v[2]));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
  endtask
  function automatic logic [15:0] pick(input int k, input logic [3:0] a, input logic ok,
                                       input logic [3:0] wa, input logic [15:0] wd);
    if (int'(a) >= dep[k]) return 16'h0;
    if (zr[k] != 0 && a == 0) return 16'h0;
    if (byp[k] != 0 && ok && wa == a) return wd;
    return m[k][a];
  endfunction
  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) m[k][i] = 16'h0;
      ea_d[k] = 16'h0; eb_d[k] = 16'h0; ea_v[k] = 1'b0; eb_v[k] = 1'b0;
    end
  endtask
  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ra_data%0d", k), 32'(ra_d[k]), 32'(ea_d[k]));
      chk($sformatf("ra_valid%0d", k), 32'(ra_v[k]), 32'(ea_v[k]));
      chk($sformatf("rb_data%0d", k), 32'(rb_d[k]), 32'(eb_d[k]));
      chk($sformatf("rb_valid%0d", k), 32'(rb_v[k]), 32'(eb_v[k]));
    end
  endtask
  task automatic step(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                      input logic ae, input logic [3:0] aa, input logic be, input logic [3:0] ba);
    logic ok [3];
    w_en = we; w_addr = wa; w_data = wd;
    ra_en = ae; ra_addr = aa; rb_en = be; rb_addr = ba;
    for (int k = 0; k < 3; k++) begin
      ok[k] = we && int'(wa) < dep[k] && !(zr[k] != 0 && wa == 0);
      if (ae) ea_d[k] = pick(k, aa, ok[k], wa, wd);
      if (be) eb_d[k] = pick(k, ba, ok[k], wa, wd);
      ea_v[k] = ae;
      eb_v[k] = be;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) if (ok[k]) m[k][wa] = wd;
    check_all();
  endtask
  initial begin
    model_reset();
    #12;
    check_all();
    @(negedge clk) reset = 1'b0;
    // reset mid-cycle clears outputs immediately and discards the stored value
    step(1, 3, 16'h1234, 1, 3, 0, 0);
    step(0, 0, 16'h0, 1, 3, 1, 3);
    #3 reset = 1'b1;
    #1 model_reset();
    check_all();
    @(negedge clk) reset = 1'b0;
    step(0, 0, 16'h0, 1, 3, 1, 3);
    for (int k = 0; k < 16; k++) step(1, 4'(k), 16'hA000 + 16'(k), 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) step(0, 0, 16'h0, 1, 4'(k), 1, 4'(15 - k));
    step(1, 5, 16'h0055, 0, 0, 0, 0);
    step(1, 5, 16'hBEEF, 1, 5, 1, 5);
    step(0, 0, 16'h0, 1, 5, 1, 5);
    step(1, 0, 16'hFFFF, 1, 0, 1, 0);
    step(0, 0, 16'h0, 1, 0, 1, 0);
    step(1, 12, 16'h7777, 0, 0, 0, 0);
    step(0, 0, 16'h0, 1, 12, 1, 2);
    step(1, 4, 16'h0444, 0, 0, 0, 0);
    step(0, 0, 16'h0, 1, 4, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 4, 16'h9999, 0, 4, 0, 4);
    for (int i = 0; i < 400; i++)
      step(1'($urandom), 4'($urandom), 16'($urandom), 1'($urandom_range(0, 3) != 0), 4'($urandom),
           1'($urandom_range(0, 3) != 0), 4'($urandom));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
